mos6502_timing: RTL and testbench
=================================

// Module: mos6502_timing
// PURPOSE
//  Sequences the 6502 core: owns the one-hot T-state register, SD1/SD2 RMW cycles and the
//  instruction register (IR). Synchronises nIRQ/nNMI, latches NMI edges and holds reset
//  requests. Injects BRK (IR=00) for interrupts and reset. Feeds T_state, IR, SD2,
//  nRESET_req, nNMI_req, nIRQ_req and READY to the decoder; consumes NEXT_T and CLEAR_T from it.
// PARAMETERS
//  SYNC_STAGES  2  flops on the nIRQ/nNMI synchronisers (legal values: 2 or 3)
// PORTS
//  clk         in   1  system clock; single clock domain
//  nRESET      in   1  asynchronous, active-low reset
//  clk_en      in   1  CPU cycle enable (PHI2 strobe); all state advances only when it is high
//  RDY         in   1  bus ready from the system
//  RnW         in   1  current cycle direction, from the decoder
//  DIR         in   8  data input register; holds the opcode during T1
//  NEXT_T      in   1  decoder: take the alternate T transition
//  CLEAR_T     in   1  decoder: enter the SD1/SD2 RMW sequence
//  PSR_I       in   1  interrupt-disable flag
//  nIRQ        in   1  asynchronous level IRQ pin
//  nNMI        in   1  asynchronous edge NMI pin
//  T_state     out  6  one-hot T0..T5; 6'b0 = SD / T6
//  SD2         out  1  second special cycle, or the BRK T6 cycle
//  IR          out  8  instruction register
//  READY       out  1  RDY | ~RnW; writes never stall
//  nRESET_req  out  1  low while the reset sequence is pending
//  nNMI_req    out  1  low while an NMI edge is pending
//  nIRQ_req    out  1  low while nIRQ_sync is low and PSR_I is 0
//  INT_INJ     out  1  high while the executing BRK was injected (suppresses PC increment and B)
// BEHAVIOUR
//  Reset values: T_state=000001, SD2=0, IR=8'h00, nRESET_req=0, nNMI_req=1, INT_INJ=1.
//  Reset also clears the synchroniser flops to 1. Reset mid-instruction aborts it immediately.
//  Advance condition: adv = clk_en & READY. No register changes when adv=0.
//  T transitions on adv (CLEAR_T has priority over NEXT_T):
//   T0: NEXT_T -> T0 (branch fix-up cycle); else -> T1
//   T1: NEXT_T -> T0 (two-cycle op); else -> T2
//   T2, T3, T4: CLEAR_T -> SD1 (T_state=0, SD2=0); NEXT_T -> T0; else -> next T
//   T5: NEXT_T -> T0; else -> SD (BRK T6); set SD2=1
//   SD, SD2=0: -> SD, set SD2=1
//   SD, SD2=1: NEXT_T -> T0; else hold
//  IR load: on adv in T1.
//   IR <= 8'h00 and INT_INJ <= 1 if any of ~nRESET_req, ~nNMI_req, ~nIRQ_req.
//   Otherwise IR <= DIR and INT_INJ <= 0.
//  Vector fetch is adv & T5 & IR==00. Exactly one request is cleared, in priority order:
//   reset, then NMI, then IRQ (IRQ is level-driven, so it only drops when the pin releases).
//   The order matches the decoder's vector select. A software BRK at T5 also consumes a
//   pending NMI (hijack).
//  NMI: falling edge of the synchronised nNMI sets the pending flag. A new edge in the same
//   cycle as the clear wins, so nNMI_req stays 0. A held-low pin never re-triggers.
//  nIRQ_req is registered every clk (not gated by clk_en), so it changes 1 clk after
//   PSR_I or nIRQ_sync changes.
//  Synchroniser latency: SYNC_STAGES clk from the pin to nIRQ_sync / the NMI edge detector.
//  RDY low on a write cycle (RnW=0) does not stall. RDY low on a read holds everything.
// STRUCTURE
//  T-state one-hot constants (`T0..`T5, `T_SD) and `OP_BRK=8'h00 go in MOS6502.vh, shared
//   with the decoder.
//  Sub-module mos6502_int_sync: per-pin SYNC_STAGES synchroniser plus NMI falling-edge
//   detector, with asynchronous reset to 1.
//  Top: T-state FSM, IR/INT_INJ register, request latches.
// TESTING
//  1 Reset release, clk_en every 4th clk, no requests -> T0,T1 then IR=00, INT_INJ=1, BRK
//    T2..T5, SD2; nRESET_req rises at T5; next T1 loads DIR into IR.
//  2 DIR=EA (NOP), NEXT_T=1 at T1 -> T0,T1,T0,T1 cycling; IR=EA; INT_INJ=0.
//  3 Opcode EE (INC abs), CLEAR_T=1 at T3 -> T3, SD1 (SD2=0), SD2 (SD2=1), then NEXT_T -> T0.
//  4 nIRQ low with PSR_I=1 -> nIRQ_req stays 1, no injection. Clear PSR_I -> nIRQ_req=0 after
//    1 clk; next T1 loads IR=00.
//  5 nNMI pulses low for 5 clk while nIRQ is held low -> NMI is taken first; nNMI_req=1 after
//    T5; IRQ is injected at the following T1.
//  6 RDY=0 on a read in T2 for 3 clk_en -> T_state and IR hold; RDY=0 with RnW=0 -> READY=1,
//    advance continues.

Source files
------------

// File: rtl/mos6502_timing_pkg.sv
// Shared timing constants for the 6502 sequencer and decoder: one-hot T-state codes,
// the injected BRK opcode and bus widths.
package mos6502_timing_pkg;

  localparam int unsigned T_W  = 6;
  localparam int unsigned IR_W = 8;

  // One-hot T0..T5; all-zero encodes the special SD1/SD2 (BRK T6) cycles.
  typedef enum logic [T_W-1:0] {
    T0   = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    T3   = 6'b001000,
    T4   = 6'b010000,
    T5   = 6'b100000,
    T_SD = 6'b000000
  } t_state_e;

  localparam logic [IR_W-1:0] OP_BRK = 8'h00;

endpackage

// File: rtl/mos6502_int_sync.sv
// Interrupt pin synchronisers (nIRQ level, nNMI level) plus the falling-edge
// detector on the synchronised nNMI. All flops reset to the idle (high) level.
module mos6502_int_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic n_irq,
  input  logic n_nmi,
  output logic n_irq_sync,
  output logic nmi_fall_c
);

  logic [SYNC_STAGES-1:0] irq_q, irq_d;
  logic [SYNC_STAGES-1:0] nmi_q, nmi_d;
  logic                   nmi_prev_q, nmi_prev_d;

  always_comb begin
    irq_d      = {irq_q[SYNC_STAGES-2:0], n_irq};
    nmi_d      = {nmi_q[SYNC_STAGES-2:0], n_nmi};
    nmi_prev_d = nmi_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q      <= '1;
      nmi_q      <= '1;
      nmi_prev_q <= 1'b1;
    end else begin
      irq_q      <= irq_d;
      nmi_q      <= nmi_d;
      nmi_prev_q <= nmi_prev_d;
    end
  end

  assign n_irq_sync = irq_q[SYNC_STAGES-1];
  assign nmi_fall_c = nmi_prev_q & ~nmi_q[SYNC_STAGES-1];

endmodule

// File: rtl/mos6502_timing.sv
// 6502 cycle sequencer: one-hot T-state FSM with SD1/SD2 RMW cycles, the instruction
// register with BRK injection, and the reset/NMI/IRQ request latches.
module mos6502_timing
  import mos6502_timing_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            nRESET,
  input  logic            clk_en,
  input  logic            RDY,
  input  logic            RnW,
  input  logic [IR_W-1:0] DIR,
  input  logic            NEXT_T,
  input  logic            CLEAR_T,
  input  logic            PSR_I,
  input  logic            nIRQ,
  input  logic            nNMI,
  output logic [T_W-1:0]  T_state,
  output logic            SD2,
  output logic [IR_W-1:0] IR,
  output logic            READY,
  output logic            nRESET_req,
  output logic            nNMI_req,
  output logic            nIRQ_req,
  output logic            INT_INJ
);

  t_state_e        t_q, t_d;
  logic            sd2_q, sd2_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            inj_q, inj_d;
  logic            rst_req_q, rst_req_d;
  logic            nmi_req_q, nmi_req_d;
  logic            irq_req_q, irq_req_d;
  logic            n_irq_sync;
  logic            nmi_fall_c;
  logic            adv;
  logic            vec_fetch;

  mos6502_int_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_int_sync (
    .clk       (clk),
    .rst_n     (nRESET),
    .n_irq     (nIRQ),
    .n_nmi     (nNMI),
    .n_irq_sync(n_irq_sync),
    .nmi_fall_c(nmi_fall_c)
  );

  // Next-state for T-state, IR and the interrupt request latches.
  always_comb begin
    t_d       = t_q;
    sd2_d     = sd2_q;
    ir_d      = ir_q;
    inj_d     = inj_q;
    rst_req_d = rst_req_q;
    nmi_req_d = nmi_req_q;
    irq_req_d = n_irq_sync | PSR_I;
    adv       = clk_en & (RDY | ~RnW);
    vec_fetch = adv && (t_q == T5) && (ir_q == OP_BRK);

    if (adv) begin
      case (t_q)
        T0: t_d = NEXT_T ? T0 : T1;
        T1: begin
          t_d = NEXT_T ? T0 : T2;
          if (!rst_req_q || !nmi_req_q || !irq_req_q) begin
            ir_d  = OP_BRK;
            inj_d = 1'b1;
          end else begin
            ir_d  = DIR;
            inj_d = 1'b0;
          end
        end
        T2, T3, T4: begin
          if (CLEAR_T) begin
            t_d   = T_SD;
            sd2_d = 1'b0;
          end else if (NEXT_T) begin
            t_d = T0;
          end else begin
            t_d = t_state_e'({t_q[T_W-2:0], 1'b0});
          end
        end
        T5: begin
          if (NEXT_T) begin
            t_d = T0;
          end else begin
            t_d   = T_SD;
            sd2_d = 1'b1;
          end
        end
        T_SD: begin
          if (!sd2_q) begin
            sd2_d = 1'b1;
          end else if (NEXT_T) begin
            t_d   = T0;
            sd2_d = 1'b0;
          end
        end
        default: begin
          t_d   = T0;
          sd2_d = 1'b0;
        end
      endcase
    end

    // One request retired per vector fetch; reset outranks NMI.
    if (vec_fetch) begin
      if (!rst_req_q) begin
        rst_req_d = 1'b1;
      end else if (!nmi_req_q) begin
        nmi_req_d = 1'b1;
      end
    end
    // A fresh NMI edge beats a simultaneous clear; edges are caught on every clk.
    if (nmi_fall_c) begin
      nmi_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      t_q       <= T0;
      sd2_q     <= 1'b0;
      ir_q      <= OP_BRK;
      inj_q     <= 1'b1;
      rst_req_q <= 1'b0;
      nmi_req_q <= 1'b1;
      irq_req_q <= 1'b1;
    end else begin
      t_q       <= t_d;
      sd2_q     <= sd2_d;
      ir_q      <= ir_d;
      inj_q     <= inj_d;
      rst_req_q <= rst_req_d;
      nmi_req_q <= nmi_req_d;
      irq_req_q <= irq_req_d;
    end
  end

  assign T_state    = t_q;
  assign SD2        = sd2_q;
  assign IR         = ir_q;
  assign INT_INJ    = inj_q;
  assign nRESET_req = rst_req_q;
  assign nNMI_req   = nmi_req_q;
  assign nIRQ_req   = irq_req_q;
  assign READY      = RDY | ~RnW;

endmodule

// File: tb/tb_mos6502_timing.sv
// Randomised scoreboard bench for mos6502_timing: a cycle-level reference model predicts
// every registered output after each clk; a separate monitor pops and compares.
module tb_mos6502_timing;

  localparam int S      = 2;
  localparam int NCYC   = 20000;
  localparam int PHASE0 = 400;

  logic       clk = 1'b0;
  logic       nRESET, clk_en, RDY, RnW, NEXT_T, CLEAR_T, PSR_I, nIRQ, nNMI;
  logic [7:0] DIR;
  logic [5:0] T_state;
  logic [7:0] IR;
  logic       SD2, READY, nRESET_req, nNMI_req, nIRQ_req, INT_INJ;

  mos6502_timing #(.SYNC_STAGES(S)) dut (
    .clk       (clk),
    .nRESET    (nRESET),
    .clk_en    (clk_en),
    .RDY       (RDY),
    .RnW       (RnW),
    .DIR       (DIR),
    .NEXT_T    (NEXT_T),
    .CLEAR_T   (CLEAR_T),
    .PSR_I     (PSR_I),
    .nIRQ      (nIRQ),
    .nNMI      (nNMI),
    .T_state   (T_state),
    .SD2       (SD2),
    .IR        (IR),
    .READY     (READY),
    .nRESET_req(nRESET_req),
    .nNMI_req  (nNMI_req),
    .nIRQ_req  (nIRQ_req),
    .INT_INJ   (INT_INJ)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] t;
    logic       sd2;
    logic [7:0] ir;
    logic       ready;
    logic       rst_req;
    logic       nmi_req;
    logic       irq_req;
    logic       inj;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: T number 0..5, 6 = special cycle; pin histories for the synchronisers.
  int       m_t;
  bit       m_sd2, m_inj, m_rst, m_nmi, m_irq;
  bit [7:0] m_ir;
  bit       irq_hist[$];
  bit       nmi_hist[$];

  task automatic model_reset();
    m_t = 0; m_sd2 = 0; m_ir = 8'h00; m_inj = 1;
    m_rst = 0; m_nmi = 1; m_irq = 1;
    irq_hist.delete();
    nmi_hist.delete();
    for (int i = 0; i <= S; i++) begin
      irq_hist.push_back(1'b1);
      nmi_hist.push_back(1'b1);
    end
  endtask

  task automatic model_step();
    bit adv, s_irq, s_nmi, p_nmi, fall, vec, any_req;
    adv     = clk_en & (RDY | ~RnW);
    s_irq   = irq_hist[irq_hist.size() - S];
    s_nmi   = nmi_hist[nmi_hist.size() - S];
    p_nmi   = nmi_hist[nmi_hist.size() - S - 1];
    fall    = p_nmi & ~s_nmi;
    vec     = adv && (m_t == 5) && (m_ir == 8'h00);
    any_req = !m_rst || !m_nmi || !m_irq;
    if (adv && m_t == 1) begin
      m_ir  = any_req ? 8'h00 : DIR;
      m_inj = any_req;
    end
    if (vec) begin
      if (!m_rst) m_rst = 1;
      else if (!m_nmi) m_nmi = 1;
    end
    if (fall) m_nmi = 0;
    m_irq = s_irq | PSR_I;
    if (adv) begin
      if (m_t == 6) begin
        if (!m_sd2) m_sd2 = 1;
        else if (NEXT_T) begin m_t = 0; m_sd2 = 0; end
      end else if (CLEAR_T && m_t >= 2 && m_t <= 4) begin
        m_t = 6; m_sd2 = 0;
      end else if (NEXT_T) begin
        m_t = 0;
      end else if (m_t == 5) begin
        m_t = 6; m_sd2 = 1;
      end else begin
        m_t = m_t + 1;
      end
    end
    irq_hist.push_back(nIRQ);
    nmi_hist.push_back(nNMI);
    if (irq_hist.size() > 16) void'(irq_hist.pop_front());
    if (nmi_hist.size() > 16) void'(nmi_hist.pop_front());
  endtask

  function automatic exp_t model_snapshot(int cyc);
    exp_t e;
    e.cyc     = cyc;
    e.t       = 6'b0;
    if (m_t < 6) e.t[m_t] = 1'b1;
    e.sd2     = m_sd2;
    e.ir      = m_ir;
    e.ready   = RDY | ~RnW;
    e.rst_req = m_rst;
    e.nmi_req = m_nmi;
    e.irq_req = m_irq;
    e.inj     = m_inj;
    return e;
  endfunction

  task automatic chk(string name, int cyc, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every clk the DUT presents a new registered state; compare it with the model.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("T_state",    e.cyc, 32'(T_state),    32'(e.t));
      chk("SD2",        e.cyc, 32'(SD2),        32'(e.sd2));
      chk("IR",         e.cyc, 32'(IR),         32'(e.ir));
      chk("READY",      e.cyc, 32'(READY),      32'(e.ready));
      chk("nRESET_req", e.cyc, 32'(nRESET_req), 32'(e.rst_req));
      chk("nNMI_req",   e.cyc, 32'(nNMI_req),   32'(e.nmi_req));
      chk("nIRQ_req",   e.cyc, 32'(nIRQ_req),   32'(e.irq_req));
      chk("INT_INJ",    e.cyc, 32'(INT_INJ),    32'(e.inj));
    end
  end

  // Stimulus: drive on the falling edge, advance the model, push the expected post-edge state.
  initial begin
    nRESET = 1'b0; clk_en = 1'b0; RDY = 1'b1; RnW = 1'b1; DIR = 8'hEA;
    NEXT_T = 1'b0; CLEAR_T = 1'b0; PSR_I = 1'b1; nIRQ = 1'b1; nNMI = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      bit do_rst;
      @(negedge clk);
      DIR = 8'($urandom);
      RnW = 1'($urandom);
      if (cyc < PHASE0) begin
        do_rst  = (cyc < 2);
        clk_en  = (cyc % 4 == 0);
        RDY     = 1'b1;
        NEXT_T  = ($urandom_range(0, 4) == 0);
        CLEAR_T = ($urandom_range(0, 5) == 0);
        PSR_I   = 1'b1;
        nIRQ    = 1'b1;
        nNMI    = 1'b1;
      end else begin
        do_rst  = ($urandom_range(0, 2499) == 0);
        clk_en  = ($urandom_range(0, 2) != 0);
        RDY     = ($urandom_range(0, 5) != 0);
        NEXT_T  = ($urandom_range(0, 4) == 0);
        CLEAR_T = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 39) == 0) PSR_I = ~PSR_I;
        if (nIRQ ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 29) == 0)) nIRQ = ~nIRQ;
        if ($urandom_range(0, 29) == 0) nNMI = ~nNMI;
      end
      nRESET = ~do_rst;
      if (do_rst) model_reset();
      else model_step();
      sb_q.push_back(model_snapshot(cyc));
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", NCYC, 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
